// File: rtl/draw_rect_char_pkg.sv
// Shared constants, bundle types and geometry helpers for the info-panel text overlay stage.
package draw_rect_char_pkg;

    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 16;
    localparam int TEXT_COLS = 16;
    localparam int TEXT_ROWS = 3;
    localparam int RGB_W     = 12;
    localparam int CNT_W     = 11;
    localparam int PIPE_LAT  = 3;

    localparam int RECT_W = CHAR_W * TEXT_COLS;
    localparam int RECT_H = CHAR_H * TEXT_ROWS;

    // One extra bit so XPOS+RECT_W never wraps in the compare.
    localparam logic [CNT_W:0] RECT_W_X = (CNT_W+1)'(RECT_W);
    localparam logic [CNT_W:0] RECT_H_X = (CNT_W+1)'(RECT_H);

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } vga_timing_t;

    typedef struct packed {
        logic             in_rect;
        logic [2:0]       col_bit;
        logic [RGB_W-1:0] rgb;
    } glyph_side_t;

    function automatic logic in_rect_f(
        input logic [CNT_W-1:0] hcount,
        input logic [CNT_W-1:0] vcount,
        input logic             hblnk,
        input logic             vblnk,
        input logic [CNT_W-1:0] xpos,
        input logic [CNT_W-1:0] ypos
    );
        logic w_h_ok;
        logic w_v_ok;
        w_h_ok = (hcount >= xpos) && ({1'b0, hcount} < ({1'b0, xpos} + RECT_W_X));
        w_v_ok = (vcount >= ypos) && ({1'b0, vcount} < ({1'b0, ypos} + RECT_H_X));
        return w_h_ok && w_v_ok && !hblnk && !vblnk;
    endfunction

    function automatic logic [7:0] char_addr_f(
        input logic [6:0] rel_x,
        input logic [5:0] rel_y
    );
        return {2'b00, rel_y[5:4], rel_x[6:3]};
    endfunction

    // Glyph rows arrive MSB-first, so column 0 of a cell selects bit 7.
    function automatic logic glyph_bit_f(
        input logic [7:0] pixels,
        input logic [2:0] col
    );
        return pixels[3'd7 - col];
    endfunction

endpackage

// File: rtl/draw_rect_char_delay.sv
// Fixed-length register delay line with asynchronous active-high clear.
module draw_rect_char_delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_stage [CLK_DEL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_din;
            for (int i = 1; i < CLK_DEL; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dout = r_stage[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_char.sv
// Info-panel text overlay: addresses the character map / font ROM and paints glyph pixels
// with a fixed 3-cycle latency on every VGA output.
module draw_rect_char
    import draw_rect_char_pkg::*;
#(
    parameter logic [CNT_W-1:0] XPOS       = 11'd16,
    parameter logic [CNT_W-1:0] YPOS       = 11'd8,
    parameter logic [RGB_W-1:0] TEXT_COLOR = 12'hfff
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] hcount_in,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic [7:0]       char_pixels,
    output logic [7:0]       char_xy,
    output logic [3:0]       char_line,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [RGB_W-1:0] rgb_out
);

    logic        w_in_rect;
    logic [6:0]  w_rel_x;
    logic [5:0]  w_rel_y;

    vga_timing_t w_timing_in;
    vga_timing_t w_timing_d3;
    glyph_side_t w_side_in;
    glyph_side_t w_side_d2;
    logic        w_glyph_on;

    logic [7:0]       r_char_xy;
    logic [3:0]       r_char_line;
    logic [RGB_W-1:0] r_rgb;

    // Only the low bits of the offsets are needed: the rectangle is 128x48.
    always_comb begin
        w_in_rect = in_rect_f(hcount_in, vcount_in, hblnk_in, vblnk_in, XPOS, YPOS);
        w_rel_x   = 7'(hcount_in - XPOS);
        w_rel_y   = 6'(vcount_in - YPOS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_char_xy   <= '0;
            r_char_line <= '0;
        end else if (w_in_rect) begin
            r_char_xy   <= char_addr_f(w_rel_x, w_rel_y);
            r_char_line <= w_rel_y[3:0];
        end else begin
            r_char_xy   <= '0;
            r_char_line <= '0;
        end
    end

    always_comb begin
        w_timing_in.hcount = hcount_in;
        w_timing_in.vcount = vcount_in;
        w_timing_in.hsync  = hsync_in;
        w_timing_in.vsync  = vsync_in;
        w_timing_in.hblnk  = hblnk_in;
        w_timing_in.vblnk  = vblnk_in;
    end

    draw_rect_char_delay #(
        .WIDTH   ($bits(vga_timing_t)),
        .CLK_DEL (PIPE_LAT)
    ) u_timing_delay (
        .clk    (clk),
        .rst    (rst),
        .i_din  (w_timing_in),
        .o_dout (w_timing_d3)
    );

    // rgb travels with the side channel for two stages; the output register adds the third.
    always_comb begin
        w_side_in.in_rect = w_in_rect;
        w_side_in.col_bit = w_rel_x[2:0];
        w_side_in.rgb     = rgb_in;
    end

    draw_rect_char_delay #(
        .WIDTH   ($bits(glyph_side_t)),
        .CLK_DEL (PIPE_LAT - 1)
    ) u_side_delay (
        .clk    (clk),
        .rst    (rst),
        .i_din  (w_side_in),
        .o_dout (w_side_d2)
    );

    always_comb begin
        w_glyph_on = w_side_d2.in_rect && glyph_bit_f(char_pixels, w_side_d2.col_bit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
        end else if (w_glyph_on) begin
            r_rgb <= TEXT_COLOR;
        end else begin
            r_rgb <= w_side_d2.rgb;
        end
    end

    assign char_xy    = r_char_xy;
    assign char_line  = r_char_line;
    assign hcount_out = w_timing_d3.hcount;
    assign vcount_out = w_timing_d3.vcount;
    assign hsync_out  = w_timing_d3.hsync;
    assign vsync_out  = w_timing_d3.vsync;
    assign hblnk_out  = w_timing_d3.hblnk;
    assign vblnk_out  = w_timing_d3.vblnk;
    assign rgb_out    = r_rgb;

endmodule

// File: tb/tb_draw_rect_char.sv
// Bench for draw_rect_char: streams pixel segments and compares every output against an
// arithmetic model of the text rectangle (16x8 origin, 128x48 size, white glyphs).
module tb_draw_rect_char;

    localparam int XPOS_M = 16;
    localparam int YPOS_M = 8;
    localparam int RW_M   = 128;
    localparam int RH_M   = 48;
    localparam int TXT_M  = 'hfff;
    localparam int MAXN   = 256;

    typedef struct {
        int h;
        int v;
        int hs;
        int vs;
        int hb;
        int vb;
        int rgb;
        int cp;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [7:0]  char_pixels = '0;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;
    pix_t seg [MAXN];
    int   segLen = 0;

    draw_rect_char dut (
        .clk         (clk),
        .rst         (rst),
        .hcount_in   (hcount_in),
        .vcount_in   (vcount_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hblnk_in    (hblnk_in),
        .vblnk_in    (vblnk_in),
        .rgb_in      (rgb_in),
        .char_pixels (char_pixels),
        .char_xy     (char_xy),
        .char_line   (char_line),
        .hcount_out  (hcount_out),
        .vcount_out  (vcount_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .hblnk_out   (hblnk_out),
        .vblnk_out   (vblnk_out),
        .rgb_out     (rgb_out)
    );

    always #5 clk = ~clk;

    function automatic pix_t mkPix(input int h, input int v, input int hs, input int vs,
                                   input int hb, input int vb, input int rgb, input int cp);
        pix_t p;
        p.h   = h;
        p.v   = v;
        p.hs  = (hs != 0) ? 1 : 0;
        p.vs  = (vs != 0) ? 1 : 0;
        p.hb  = (hb != 0) ? 1 : 0;
        p.vb  = (vb != 0) ? 1 : 0;
        p.rgb = rgb & 'hfff;
        p.cp  = cp & 'hff;
        return p;
    endfunction

    // Anything before or after the current segment is an idle all-zero pixel.
    function automatic pix_t pixAt(input int i);
        if (i < 0 || i >= segLen) return mkPix(0, 0, 0, 0, 0, 0, 0, 0);
        return seg[i];
    endfunction

    function automatic bit inRect(input pix_t p);
        return p.h >= XPOS_M && p.h < XPOS_M + RW_M && p.v >= YPOS_M && p.v < YPOS_M + RH_M
               && p.hb == 0 && p.vb == 0;
    endfunction

    function automatic int expXy(input pix_t p);
        if (!inRect(p)) return 0;
        return ((p.v - YPOS_M) / 16) * 16 + (p.h - XPOS_M) / 8;
    endfunction

    function automatic int expLine(input pix_t p);
        if (!inRect(p)) return 0;
        return (p.v - YPOS_M) % 16;
    endfunction

    function automatic int expRgb(input pix_t p);
        int col;
        if (!inRect(p)) return p.rgb;
        col = (p.h - XPOS_M) % 8;
        if (((p.cp >> (7 - col)) & 1) == 1) return TXT_M;
        return p.rgb;
    endfunction

    task automatic checkValue(input string tag, input logic [37:0] observed,
                              input logic [37:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at negedge k: char stage reflects pixel k-1, pixel pipe reflects pixel k-3.
    task automatic checkOutput(input int k);
        pix_t a;
        pix_t b;
        a = pixAt(k - 1);
        b = pixAt(k - 3);
        checkValue($sformatf("char_xy@%0d", k), 38'(char_xy), 38'(expXy(a)));
        checkValue($sformatf("char_line@%0d", k), 38'(char_line), 38'(expLine(a)));
        checkValue($sformatf("hcount_out@%0d", k), 38'(hcount_out), 38'(b.h));
        checkValue($sformatf("vcount_out@%0d", k), 38'(vcount_out), 38'(b.v));
        checkValue($sformatf("sync_blank@%0d", k),
                   38'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
                   38'(b.hs * 8 + b.vs * 4 + b.hb * 2 + b.vb));
        checkValue($sformatf("rgb_out@%0d", k), 38'(rgb_out), 38'(expRgb(b)));
    endtask

    // Drives pixel k, plus the glyph row that belongs to pixel k-2.
    task automatic applyStimulus(input int k);
        pix_t p;
        int   q;
        p = pixAt(k);
        hcount_in = 11'(p.h);
        vcount_in = 11'(p.v);
        hsync_in  = 1'(p.hs);
        vsync_in  = 1'(p.vs);
        hblnk_in  = 1'(p.hb);
        vblnk_in  = 1'(p.vb);
        rgb_in    = 12'(p.rgb);
        q = k - 2;
        if (q >= 0 && q < segLen) char_pixels = 8'(seg[q].cp);
        else char_pixels = 8'($urandom);
    endtask

    task automatic runSegment(input int n, input int tail);
        segLen = n;
        for (int k = 0; k < n + tail; k++) begin
            @(negedge clk);
            checkOutput(k);
            applyStimulus(k);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, "_char_xy"}, 38'(char_xy), 38'(0));
        checkValue({tag, "_char_line"}, 38'(char_line), 38'(0));
        checkValue({tag, "_hcount"}, 38'(hcount_out), 38'(0));
        checkValue({tag, "_vcount"}, 38'(vcount_out), 38'(0));
        checkValue({tag, "_sync_blank"},
                   38'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 38'(0));
        checkValue({tag, "_rgb"}, 38'(rgb_out), 38'(0));
    endtask

    initial begin
        // Power-on reset: outputs clear without waiting for a clock edge.
        #1 rst = 1'b1;
        #1 checkAllZero("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Random traffic strictly below the rectangle: pure 3-cycle pass-through.
        for (int i = 0; i < 40; i++) begin
            seg[i] = mkPix(int'($urandom_range(0, 1023)), int'($urandom_range(60, 767)),
                           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           int'($urandom), int'($urandom));
        end
        runSegment(40, 3);

        // Directed corners, edges and blanking cases.
        seg[0]  = mkPix(16, 8, 0, 0, 0, 0, 'h321, 'h80);
        seg[1]  = mkPix(16, 8, 0, 0, 0, 0, 'h123, 'h7f);
        seg[2]  = mkPix(96, 29, 1, 0, 0, 0, 'h456, int'($urandom));
        seg[3]  = mkPix(143, 8, 0, 1, 0, 0, 'h0ab, 'h01);
        seg[4]  = mkPix(144, 8, 0, 0, 0, 0, 'h0cd, 'hff);
        seg[5]  = mkPix(20, 55, 0, 0, 0, 0, 'h111, 'hff);
        seg[6]  = mkPix(20, 56, 0, 0, 0, 0, 'h222, 'hff);
        seg[7]  = mkPix(15, 8, 0, 0, 0, 0, 'h333, 'hff);
        seg[8]  = mkPix(16, 7, 0, 0, 0, 0, 'h444, 'hff);
        seg[9]  = mkPix(40, 20, 0, 0, 1, 0, 'h000, 'hff);
        seg[10] = mkPix(40, 20, 0, 0, 0, 1, 'h000, 'hff);
        seg[11] = mkPix(143, 55, 1, 1, 0, 0, 'h555, 'h01);
        runSegment(12, 3);

        // Random traffic around and inside the rectangle.
        for (int i = 0; i < 150; i++) begin
            seg[i] = mkPix(int'($urandom_range(0, 200)), int'($urandom_range(0, 70)),
                           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           ($urandom_range(0, 7) == 0) ? 1 : 0,
                           ($urandom_range(0, 15) == 0) ? 1 : 0,
                           int'($urandom), int'($urandom));
        end
        runSegment(150, 3);

        // Reset in the middle of in-rectangle pixels.
        for (int i = 0; i < 6; i++) begin
            seg[i] = mkPix(XPOS_M + 8 * i + 3, YPOS_M + 17, 1, 1, 0, 0, 'h7a5, 'hff);
        end
        runSegment(6, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkAllZero("rst_async");
        @(posedge clk);
        #1 checkAllZero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        segLen = 0;
        applyStimulus(0);

        // Restart after reset: flushed zeros first, then correct pixels.
        for (int i = 0; i < 40; i++) begin
            seg[i] = mkPix(int'($urandom_range(10, 150)), int'($urandom_range(4, 60)),
                           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           0, 0, int'($urandom), int'($urandom));
        end
        runSegment(40, 3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
